// File: rtl/dff_checker.sv
// Clocked response checker for a D flip-flop with active-low async set/reset.
// Tracks the expected flip-flop mode, checks q/qbar, and keeps saturating counters.
module dff_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             dut_d,
  input  logic             dut_lset,
  input  logic             dut_res,
  input  logic             dut_q,
  input  logic             dut_qbar,
  output logic             err_pulse,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] err_count,
  output logic [2:0]       mode,
  output logic             sim_release
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    ASET  = 3'd2,
    ARES  = 3'd3,
    BOTH  = 3'd4,
    RECOV = 3'd5
  } state_t;

  localparam logic [3:0]       SETTLE  = 4'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state, state_next;
  logic       exp_q, exp_q_next;
  logic [3:0] settle, settle_next;
  logic       chk_next, err_next, release_next;
  logic [2:0] code_next;
  logic       sync_fail, qbar_fail, set_fail, rst_fail, both_fail;

  always_comb begin
    state_next   = state;
    exp_q_next   = exp_q;
    settle_next  = '0;
    chk_next     = 1'b0;
    release_next = 1'b0;
    sync_fail    = 1'b0;
    qbar_fail    = 1'b0;
    set_fail     = 1'b0;
    rst_fail     = 1'b0;
    both_fail    = 1'b0;

    case ({dut_lset, dut_res})
      2'b00:   state_next = BOTH;
      2'b01:   state_next = ASET;
      2'b10:   state_next = ARES;
      default: begin
        if (state == ASET || state == ARES || state == BOTH)
          state_next = RECOV;
        else
          state_next = SYNC;
      end
    endcase

    // Any change of async mode restarts the settle window.
    if (state_next == ASET || state_next == ARES || state_next == BOTH) begin
      if (state_next != state)
        settle_next = '0;
      else if (settle < SETTLE)
        settle_next = settle + 4'd1;
      else
        settle_next = settle;
    end

    case (state_next)
      SYNC: begin
        exp_q_next = dut_d;
        if (state != IDLE) begin
          chk_next  = 1'b1;
          sync_fail = (dut_q != exp_q);
          qbar_fail = (dut_qbar == dut_q);
        end
      end
      ASET: begin
        if (settle_next == SETTLE) begin
          chk_next  = 1'b1;
          set_fail  = !(dut_q && !dut_qbar);
          qbar_fail = (dut_qbar == dut_q);
        end
      end
      ARES: begin
        if (settle_next == SETTLE) begin
          chk_next  = 1'b1;
          rst_fail  = !(!dut_q && dut_qbar);
          qbar_fail = (dut_qbar == dut_q);
        end
      end
      BOTH: begin
        if (settle_next == SETTLE) begin
          chk_next  = 1'b1;
          both_fail = !(dut_q && dut_qbar);
        end
      end
      RECOV: begin
        exp_q_next   = dut_d;
        release_next = (state == BOTH);
      end
      default: ;
    endcase

    err_next = sync_fail | qbar_fail | set_fail | rst_fail | both_fail;
    if (sync_fail)      code_next = 3'd1;
    else if (qbar_fail) code_next = 3'd2;
    else if (set_fail)  code_next = 3'd3;
    else if (rst_fail)  code_next = 3'd4;
    else if (both_fail) code_next = 3'd5;
    else                code_next = 3'd0;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state       <= IDLE;
      exp_q       <= 1'b0;
      settle      <= '0;
      err_pulse   <= 1'b0;
      err_code    <= '0;
      check_count <= '0;
      err_count   <= '0;
      sim_release <= 1'b0;
    end else begin
      state       <= state_next;
      exp_q       <= exp_q_next;
      settle      <= settle_next;
      err_pulse   <= err_next;
      sim_release <= release_next;
      if (err_next)
        err_code <= code_next;
      if (chk_next && check_count != CNT_MAX)
        check_count <= check_count + 1'b1;
      if (err_next && err_count != CNT_MAX)
        err_count <= err_count + 1'b1;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_dff_checker.sv
// Directed bench for dff_checker: hand-computed expectations for a 16-bit and a 2-bit counter build.
module tb_dff_checker;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic d = 1'b0, lset = 1'b1, rst = 1'b1, q = 1'b0, qbar = 1'b1;

  logic        pulse, rel, pulse_s, rel_s;
  logic [2:0]  code, mode, code_s, mode_s;
  logic [15:0] chk, err;
  logic [1:0]  chk_s, err_s;

  int assert_count = 0;
  int fail_count   = 0;

  always #5 clk = ~clk;

  dff_checker u_dut (
    .clk(clk), .res(res), .dut_d(d), .dut_lset(lset), .dut_res(rst),
    .dut_q(q), .dut_qbar(qbar), .err_pulse(pulse), .err_code(code),
    .check_count(chk), .err_count(err), .mode(mode), .sim_release(rel)
  );

  dff_checker #(.SETTLE_CYCLES(2), .CNT_W(2)) u_small (
    .clk(clk), .res(res), .dut_d(d), .dut_lset(lset), .dut_res(rst),
    .dut_q(q), .dut_qbar(qbar), .err_pulse(pulse_s), .err_code(code_s),
    .check_count(chk_s), .err_count(err_s), .mode(mode_s), .sim_release(rel_s)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkState(input string tag, input logic p, input logic [2:0] c,
                            input logic [15:0] n_chk, input logic [15:0] n_err,
                            input logic [2:0] m, input logic r);
    checkOutput({tag, ".err_pulse"}, 32'(pulse), 32'(p));
    checkOutput({tag, ".err_code"}, 32'(code), 32'(c));
    checkOutput({tag, ".check_count"}, 32'(chk), 32'(n_chk));
    checkOutput({tag, ".err_count"}, 32'(err), 32'(n_err));
    checkOutput({tag, ".mode"}, 32'(mode), 32'(m));
    checkOutput({tag, ".sim_release"}, 32'(rel), 32'(r));
  endtask

  task automatic applyStimulus(input logic nd, input logic nlset, input logic nrst,
                               input logic nq, input logic nqbar);
    d = nd; lset = nlset; rst = nrst; q = nq; qbar = nqbar;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkState("reset", 0, 0, 0, 0, 0, 0);
    checkOutput("reset.small_mode", 32'(mode_s), 0);
    res = 1'b1;

    // SYNC with a correct flip-flop: d = 1,0,1,1
    applyStimulus(1, 1, 1, 0, 1);
    checkState("p1", 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(1, 1, 1, 0, 1);
    applyStimulus(1, 1, 1, 1, 0);
    checkState("sync_ok", 0, 0, 3, 0, 1, 0);

    // q low while 1 expected
    applyStimulus(0, 1, 1, 0, 1);
    checkState("sync_err", 1, 1, 4, 1, 1, 0);
    applyStimulus(0, 1, 1, 0, 1);
    checkState("sync_recover", 0, 1, 5, 1, 1, 0);

    // async set held 5 cycles, correct response
    applyStimulus(0, 0, 1, 1, 0);
    checkState("aset_enter", 0, 1, 5, 1, 2, 0);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 1, 1, 0);
    checkState("aset_settled", 0, 1, 6, 1, 2, 0);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 1, 1, 0);
    checkState("aset_hold", 0, 1, 8, 1, 2, 0);
    applyStimulus(1, 1, 1, 1, 0);
    checkState("aset_recov", 0, 1, 8, 1, 5, 0);
    applyStimulus(1, 1, 1, 1, 0);
    checkState("aset_resume", 0, 1, 9, 1, 1, 0);

    // async set with q stuck at 0
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 1, 0, 1);
    checkState("aset_stuck_wait", 0, 1, 9, 1, 2, 0);
    applyStimulus(0, 0, 1, 0, 1);
    checkState("aset_stuck", 1, 3, 10, 2, 2, 0);
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 1, 0, 1);
    checkState("aset_stuck_hold", 1, 3, 12, 4, 2, 0);
    checkOutput("small.err_sat", 32'(err_s), 3);
    checkOutput("small.chk_sat", 32'(chk_s), 3);
    applyStimulus(0, 1, 1, 0, 1);
    checkState("aset2_recov", 0, 3, 12, 4, 5, 0);
    applyStimulus(0, 1, 1, 0, 1);
    checkState("aset2_resume", 0, 3, 13, 4, 1, 0);

    // reset then both low, released together
    applyStimulus(0, 1, 0, 1, 1);
    checkState("ares_enter", 0, 3, 13, 4, 3, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkState("both_enter", 0, 3, 13, 4, 4, 0);
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 1);
    checkState("both_settled", 0, 3, 14, 4, 4, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkState("both_hold", 0, 3, 15, 4, 4, 0);
    applyStimulus(1, 1, 1, 1, 1);
    checkState("both_release", 0, 3, 15, 4, 5, 1);
    applyStimulus(1, 1, 1, 1, 0);
    checkState("both_resume", 0, 3, 16, 4, 1, 0);

    // q mismatch and qbar==q together: lowest code wins
    applyStimulus(0, 1, 1, 0, 0);
    checkState("prio", 1, 1, 17, 5, 1, 0);
    applyStimulus(0, 1, 1, 0, 1);
    checkState("prio_clear", 0, 1, 18, 5, 1, 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkState("qbar_only", 1, 2, 19, 6, 1, 0);
    applyStimulus(0, 1, 1, 0, 1);
    checkState("qbar_clear", 0, 2, 20, 6, 1, 0);

    // async reset with q stuck at 1
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 0);
    checkState("ares_wait", 0, 2, 20, 6, 3, 0);
    applyStimulus(0, 1, 0, 1, 0);
    checkState("ares_fail", 1, 4, 21, 7, 3, 0);

    // both low but qbar stays low
    applyStimulus(0, 0, 0, 1, 0);
    checkState("both2_enter", 0, 4, 21, 7, 4, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkState("both_fail", 1, 5, 22, 8, 4, 0);
    checkOutput("small.err_still_sat", 32'(err_s), 3);

    // checker reset mid-sequence clears everything without a clock edge
    #2;
    res = 1'b0;
    #1;
    checkState("async_reset", 0, 0, 0, 0, 0, 0);
    checkOutput("small.err_reset", 32'(err_s), 0);
    checkOutput("small.mode_reset", 32'(mode_s), 0);
    @(negedge clk);
    res = 1'b1;
    applyStimulus(1, 1, 1, 0, 1);
    checkState("restart_load", 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 1, 1, 0);
    checkState("restart_check", 0, 0, 1, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/dff_checker.md
Name: dff_checker

Overview:
- Synthesizable, clocked response checker for the D flip-flop. It is the observing end of the DFF stimulus interface.
- Each cycle it samples the stimulus (d, lset, res) and the response (q, qbar) on the shared clk.
- It tracks the mode the flip-flop should be in (synchronous, set, reset, both, recovery) and checks the outputs against that mode.
- It reports each mismatch as a coded error pulse and keeps saturating pass/fail counters. It sits in the cocotb bench alongside the DUT.

Parameters:
- SETTLE_CYCLES, 2, number of posedges after an async set/reset assertion before the async output value is checked (1..15).
- CNT_W, 16, width of the check_count and err_count counters.

Ports:
- clk  input  1  bench clock; the same clock that drives the DUT.
- res  input  1  checker reset, asynchronous, active-low.
- dut_d  input  1  D input as driven to the DUT.
- dut_lset  input  1  DUT set, active-low.
- dut_res  input  1  DUT reset, active-low.
- dut_q  input  1  DUT q output.
- dut_qbar  input  1  DUT qbar output.
- err_pulse  output  1  one-cycle strobe on any detected error.
- err_code  output  3  code of the last error (held until the next error).
- check_count  output  CNT_W  number of checks performed, saturating.
- err_count  output  CNT_W  number of errors, saturating.
- mode  output  3  current FSM state encoding.
- sim_release  output  1  one-cycle flag: dut_lset and dut_res released on the same posedge.

Behaviour:
- Reset (res=0), asynchronous:
  - FSM goes to IDLE.
  - All outputs are 0; exp_q is 0 and the settle counter is 0.
  - Reset mid-check discards the check in progress.
- Sampling: all dut_* inputs are synchronous to clk and are sampled on posedge. All state updates on posedge.
- FSM state encodings:
  - IDLE=0, SYNC=1, ASET=2, ARES=3, BOTH=4, RECOV=5.
- FSM transitions, evaluated on the sampled dut_lset/dut_res each posedge, in this priority:
  - lset=0 and res=0: go to BOTH.
  - lset=0 and res=1: go to ASET.
  - lset=1 and res=0: go to ARES.
  - Both 1, previous state ASET, ARES or BOTH: go to RECOV.
  - Both 1, previous state IDLE: go to SYNC. No check this cycle; exp_q is loaded with dut_d.
  - RECOV goes to SYNC on the next posedge.
- Settle counter:
  - Clears on entry to ASET, ARES or BOTH, including a switch between them.
  - Increments each cycle in those states and saturates at SETTLE_CYCLES.
- SYNC check:
  - Latency 1: at posedge n, dut_q must equal dut_d sampled at posedge n-1 (exp_q).
  - exp_q is then reloaded with the current dut_d.
- qbar check: in SYNC, ASET and ARES checks, dut_qbar must equal ~dut_q.
- Async checks:
  - Made only when the settle counter equals SETTLE_CYCLES.
  - ASET: q=1, qbar=0.
  - ARES: q=0, qbar=1.
  - BOTH: q=1, qbar=1.
- RECOV:
  - No check. exp_q is loaded with dut_d so that SYNC checking resumes on the next cycle.
  - If the previous state was BOTH and both inputs rose on the same posedge, sim_release=1 for one cycle. No check is made; the q value is undefined.
- Error codes:
  - 1 SYNC_MISMATCH
  - 2 QBAR_NOT_COMPLEMENT
  - 3 SET_FAIL
  - 4 RESET_FAIL
  - 5 BOTH_FAIL
  - Code 0 means no error since reset.
  - If several errors occur in one cycle, the lowest code wins. Only one err_pulse and one err_count increment per cycle.
- Counters:
  - check_count increments on every cycle where any check is evaluated.
  - err_count increments with each err_pulse.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- Output timing: all outputs are registered. err_pulse is asserted in the cycle after the failing sample.

Test Plan:
- Reset release, then d toggling 1,0,1,1 with the DUT correct:
  - Required: err_count=0 and check_count=3 after 4 posedges (first cycle only loads exp_q).
  - Required: mode=1 (SYNC).
- Force dut_q=0 when exp_q=1 in SYNC:
  - Required: err_pulse high for 1 cycle, err_code=1, err_count=1.
- Hold dut_lset=0 for 5 cycles with q=1, qbar=0, SETTLE_CYCLES=2:
  - Required: no error and check_count +3.
  - Repeat with q stuck at 0: err_code=3.
- Drive dut_res=0 then dut_lset=0 (both low) with q=qbar=1:
  - Required: mode steps 3 then 4; after settle, no error.
  - Release both on the same posedge: sim_release=1 for one cycle, mode 5 then 1.
- Force dut_qbar=dut_q in SYNC together with a q mismatch:
  - Required: err_code=1 (priority), err_count +1 only.
- Preload err_count to 2^CNT_W-2 (CNT_W=2 build), inject 3 errors:
  - Required: err_count saturates at 3.
  - Assert res mid-sequence: all outputs return to 0 and mode=0 asynchronously.
